bitplane_read_ctrl: RTL and testbench
=====================================

# bitplane_read_ctrl

Sequences a full-image bit-plane read for the image pipeline. On `start`, it walks the pixel memory once per bit plane (plane 0 through plane `PIX_W-1`) and extracts the selected bit of every pixel. It packs those bits LSB-first into `WORD_W`-bit words and streams the words to the downstream bit-plane consumer over a valid/ready handshake. It is the controller that owns the pixel-memory read port and the framing of the 200-bit plane words.

## Interface
- `IMG_SIZE`, 1024: pixels per image.
- `PIX_W`, 8: bits per pixel, which is also the number of planes.
- `WORD_W`, 200: output word width in bits.
- `ADDR_W`, 10: pixel-memory address width; must satisfy `2**ADDR_W >= IMG_SIZE`.
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse after the final word handshake.
- `mem_en`  out  1  pixel read strobe.
- `mem_addr`  out  ADDR_W  pixel address.
- `mem_data`  in  PIX_W  read data, valid exactly 1 cycle after `mem_en`.
- `out_data`  out  WORD_W  packed plane bits.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts.
- `out_plane`  out  clog2(PIX_W)  plane index of the current word.
- `out_last`  out  1  current word is the last word of its plane.

## Operation
- FSM states:
  - IDLE: `start` goes to READ.
  - READ: issues one read per cycle. On the read that supplies bit `WORD_W-1` of the word, or the read of pixel `IMG_SIZE-1`, go to FLUSH.
  - FLUSH: no read issued; captures the final in-flight bit; go to EMIT.
  - EMIT: `out_valid=1`; wait for `out_ready`.
  - DONE: one cycle, `done=1`, then IDLE.
- EMIT exit on handshake:
  - Word not last of plane: go to READ, address continues.
  - Last word of a plane other than the final plane: increment plane, reset address to 0, go to READ.
  - Last word of plane `PIX_W-1`: go to DONE.
- Packing: pixel k of the plane lands at bit `k mod WORD_W`. A partial final word is zero in all unused upper bits. The accumulator is cleared after each handshake.
- Words per plane are ceil(IMG_SIZE/WORD_W). With the default parameters this is 6: five full words plus one 24-bit word with bits 199:24 equal to 0. The image total is 48 words.
- `out_data`, `out_plane` and `out_last` stay stable while `out_valid=1` and `out_ready=0`.
- `start` is ignored when not in IDLE.
- `mem_addr` holds its last value when `mem_en=0`.

## Timing
- Reset values: FSM in IDLE; `busy`, `done`, `mem_en`, `out_valid` and `out_last` are 0; `mem_addr`, `out_data` and `out_plane` are 0.
- Reset mid-operation returns the block immediately to IDLE with the reset values; the in-flight read is discarded.
- Cycle numbering: `start` is sampled at edge 0.
  - `busy=1` and `mem_en=1` with `mem_addr=0` from cycle 1.
  - Reads occur in cycles 1..200 (addresses 0..199).
  - Cycle 201 is FLUSH.
  - `out_valid` rises in cycle 202.
- A handshake in cycle t (`out_valid & out_ready`) puts the FSM in READ at cycle t+1, with `mem_en=1` at the next address.
- Per-word cost is the number of bits + 2 + stall cycles. The minimal full image takes 8×(1024+6×2) cycles plus the DONE cycle.
- `done` is high for exactly the cycle after the final handshake; `busy` falls in that same cycle.
- `out_valid` never deasserts without a handshake, except on reset.

## Structure
- Shared package `image_pkg`:
  - constants `IMG_SIZE`, `PIX_W`, `WORD_W`, `ADDR_W`, and the derived words-per-plane;
  - FSM state encoding (IDLE, READ, FLUSH, EMIT, DONE).
- Sub-module `bitplane_packer`:
  - `WORD_W` accumulator plus a clog2(`WORD_W`) bit index;
  - inputs: bit, write enable, clear;
  - output: packed word.
- The controller owns the FSM, address counter, plane counter and word counter.

## Test plan
- Reset, then `start` with `out_ready` held at 1 and memory `data[a] = a[7:0]`:
  - first word arrives at cycle 202, `out_plane=0`, `out_data` bit k equal to k[0] (alternating pattern);
  - 48 words total;
  - `done` pulses once after word 48.
- Partial word: 6th word of every plane has `out_last=1`, bits 199:24 = 0, bits 23:0 equal to plane bits of pixels 1000..1023.
- Backpressure: `out_ready=0` for 10 cycles on word 3. Required:
  - `out_data` stable throughout;
  - `mem_en=0` throughout;
  - after the handshake, `mem_addr` resumes at 600.
- Plane rollover: after the 6th handshake of plane 2, `out_plane` becomes 3 and the next read is `mem_addr=0`.
- `start` pulsed while busy has no effect: word count stays 48 and there is a single `done`.
- Assert `rst` in cycle 500 with `out_valid` high. Required:
  - all outputs return to their reset values asynchronously;
  - a new `start` reproduces the first-word timing (cycle 202).

Source files
------------

// File: rtl/image_pkg.sv
// Shared constants and FSM state encoding for the bit-plane read path.
package image_pkg;
  localparam int IMG_SIZE        = 1024;
  localparam int PIX_W           = 8;
  localparam int WORD_W          = 200;
  localparam int ADDR_W          = 10;
  localparam int WORDS_PER_PLANE = (IMG_SIZE + WORD_W - 1) / WORD_W;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_EMIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
endpackage

// File: rtl/bitplane_packer.sv
// LSB-first bit accumulator: each write lands at the next bit index.
module bitplane_packer #(
  parameter  int WORD_W = 200,
  localparam int IDX_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_bit,
  input  logic              wen,
  input  logic              clear,
  output logic [WORD_W-1:0] word
);
  logic [IDX_W-1:0] idx;

  // Clear wins so a fresh word always starts from all-zero upper bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
      idx  <= '0;
    end else if (clear) begin
      word <= '0;
      idx  <= '0;
    end else if (wen) begin
      word[idx] <= data_bit;
      idx       <= idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/bitplane_read_ctrl.sv
// Walks pixel memory once per bit plane and streams packed plane words.
module bitplane_read_ctrl #(
  parameter  int IMG_SIZE = image_pkg::IMG_SIZE,
  parameter  int PIX_W    = image_pkg::PIX_W,
  parameter  int WORD_W   = image_pkg::WORD_W,
  parameter  int ADDR_W   = image_pkg::ADDR_W,
  localparam int PL_W     = (PIX_W > 1) ? $clog2(PIX_W) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PL_W-1:0]   out_plane,
  output logic              out_last
);
  import image_pkg::*;

  localparam int IDX_W = $clog2(WORD_W);
  localparam int WPP   = (IMG_SIZE + WORD_W - 1) / WORD_W;
  localparam int WC_W  = (WPP > 1) ? $clog2(WPP) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(IMG_SIZE - 1);
  localparam logic [PL_W-1:0]   PLANE_LAST = PL_W'(PIX_W - 1);
  localparam logic [WC_W-1:0]   WORD_LAST  = WC_W'(WPP - 1);

  logic [2:0]       state, state_nx;
  logic [IDX_W-1:0] rd_idx;
  logic [WC_W-1:0]  word_cnt;
  logic [PL_W-1:0]  plane;
  logic             rd_pend;
  logic             start_ok, word_end, hs, last_word;

  assign start_ok  = (state == ST_IDLE) && start;
  assign mem_en    = (state == ST_READ);
  assign word_end  = (rd_idx == IDX_LAST) || (mem_addr == ADDR_LAST);
  assign out_valid = (state == ST_EMIT);
  assign hs        = out_valid && out_ready;
  assign last_word = (word_cnt == WORD_LAST);
  assign out_last  = out_valid && last_word;
  assign out_plane = plane;
  assign busy      = (state == ST_READ) || (state == ST_FLUSH) || (state == ST_EMIT);
  assign done      = (state == ST_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_READ;
      ST_READ:  if (word_end) state_nx = ST_FLUSH;
      ST_FLUSH: state_nx = ST_EMIT;
      ST_EMIT:  if (hs) state_nx = (last_word && plane == PLANE_LAST) ? ST_DONE : ST_READ;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // The address only advances between reads, so it holds the last issued
  // address through FLUSH/EMIT and resumes from there after the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      rd_idx   <= '0;
      word_cnt <= '0;
      plane    <= '0;
      rd_pend  <= 1'b0;
    end else begin
      state   <= state_nx;
      rd_pend <= mem_en;
      if (start_ok) begin
        mem_addr <= '0;
        rd_idx   <= '0;
        word_cnt <= '0;
        plane    <= '0;
      end else if (mem_en && !word_end) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        rd_idx   <= rd_idx + IDX_W'(1);
      end else if (hs) begin
        rd_idx <= '0;
        if (!last_word) begin
          word_cnt <= word_cnt + WC_W'(1);
          mem_addr <= mem_addr + ADDR_W'(1);
        end else begin
          word_cnt <= '0;
          if (plane != PLANE_LAST) begin
            plane    <= plane + PL_W'(1);
            mem_addr <= '0;
          end
        end
      end
    end
  end

  // Read data returns one cycle after mem_en; plane is constant across a word.
  bitplane_packer #(.WORD_W(WORD_W)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .data_bit (mem_data[plane]),
    .wen      (rd_pend),
    .clear    (hs || start_ok),
    .word     (out_data)
  );
endmodule

// File: tb/tb_bitplane_read_ctrl.sv
// Scoreboard bench: expected words are queued at start, a monitor pops on handshake.
module tb_bitplane_read_ctrl;
  import image_pkg::*;
  localparam int PL_W = $clog2(PIX_W);

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
  logic busy, done, mem_en, out_valid, out_last;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_data = '0;
  logic [WORD_W-1:0] out_data;
  logic [PL_W-1:0]   out_plane;

  typedef struct {
    logic [WORD_W-1:0] data;
    int                plane;
    bit                last;
  } exp_t;
  exp_t sb[$];

  int chk = 0, pass = 0, done_cnt = 0, words = 0;

  always #5 clk = ~clk;

  bitplane_read_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_plane(out_plane), .out_last(out_last)
  );

  // Pixel memory: data[a] = a[7:0], one-cycle read latency.
  always @(posedge clk) if (mem_en) mem_data <= mem_addr[7:0];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    chk++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [WORD_W-1:0] exp_word(input int p, input int w);
    logic [WORD_W-1:0] r = '0;
    for (int k = 0; k < WORD_W; k++) begin
      int px = w * WORD_W + k;
      if (px < IMG_SIZE) r[k] = (((px % 256) >> p) & 1) != 0;
    end
    return r;
  endfunction

  task automatic push_image();
    exp_t e;
    for (int p = 0; p < PIX_W; p++)
      for (int w = 0; w < WORDS_PER_PLANE; w++) begin
        e.data = exp_word(p, w);
        e.plane = p;
        e.last = (w == WORDS_PER_PLANE - 1);
        sb.push_back(e);
      end
  endtask

  // Monitor: compare every handshaken word against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) done_cnt++;
    if (!rst && out_valid && out_ready) begin
      words++;
      if (sb.size() == 0) check("sb_underflow", 256'(1), 256'(0));
      else begin
        e = sb.pop_front();
        check("word_data", 256'(out_data), 256'(e.data));
        check("word_plane", 256'(out_plane), 256'(e.plane));
        check("word_last", 256'(out_last), 256'(e.last));
      end
    end
  end

  // Pulse start; returns at the negedge of cycle 1 with cyc = 1.
  task automatic do_start(output int cyc);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    cyc = 1;
    check("c1_busy_en_addr", 256'({busy, mem_en, mem_addr}), 256'({2'b11, {ADDR_W{1'b0}}}));
  endtask

  task automatic first_word_timing();
    int cyc;
    do_start(cyc);
    while (!out_valid && cyc < 400) begin @(negedge clk); cyc++; end
    check("first_valid_cycle", 256'(cyc), 256'(202));
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!out_valid && n < 1000) begin @(negedge clk); n++; end
    ok = out_valid;
  endtask

  // Walks the 48 words from a negedge inside the first word's valid cycle.
  task automatic run_image(input bit special);
    logic [WORD_W-1:0] alt = {100{2'b10}};
    logic [WORD_W-1:0] hold;
    bit ok, stable;
    for (int w = 0; w < PIX_W * WORDS_PER_PLANE; w++) begin
      wait_valid(ok);
      if (!ok) begin
        check("valid_timeout", 256'(0), 256'(1));
        return;
      end
      if (w == 0) check("w0_alternating", 256'(out_data), 256'(alt));
      if (w == 5) check("p0_partial", 256'({out_last, out_data}), 256'({1'b1, 200'hAAAAAA}));
      if (w == 11) check("p1_partial", 256'({out_last, out_data}), 256'({1'b1, 200'hCCCCCC}));
      if (special && w == 2) begin
        hold = out_data;
        stable = 1'b1;
        repeat (9) begin
          @(negedge clk);
          if (!out_valid || mem_en || out_data !== hold) stable = 1'b0;
        end
        check("stall_hold", 256'(stable), 256'(1));
        @(posedge clk); #1 out_ready = 1'b1;
      end
      @(posedge clk);
      #1 if (special && w == 1) out_ready = 1'b0;
      @(negedge clk);
      if (special && w == 2)
        check("resume_addr", 256'({mem_en, mem_addr}), 256'({1'b1, ADDR_W'(600)}));
      if (w == 17)
        check("rollover", 256'({mem_en, out_plane, mem_addr}), 256'({1'b1, PL_W'(3), ADDR_W'(0)}));
      if (w == PIX_W * WORDS_PER_PLANE - 1)
        check("done_pulse", 256'({done, busy}), 256'(2'b10));
      if (special && w == 20) begin
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    end
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    check("reset_outputs", 256'({busy, done, mem_en, out_valid, out_last, mem_addr, out_data, out_plane}), 256'(0));
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;

    // Run 1: stall on word 3, start pulsed mid-run.
    push_image();
    first_word_timing();
    run_image(1'b1);
    repeat (5) @(negedge clk);
    check("run1_words", 256'(words), 256'(48));
    check("run1_done_cnt", 256'(done_cnt), 256'(1));
    check("run1_sb_empty", 256'(sb.size()), 256'(0));

    // Run 2: reset while a word is stuck valid, then a clean restart.
    @(posedge clk); #1 out_ready = 1'b0;
    do_start(cyc);
    while (cyc < 500) begin @(negedge clk); cyc++; end
    check("pre_rst_valid", 256'(out_valid), 256'(1));
    #1 rst = 1'b1;
    #1 check("async_reset", 256'({busy, done, mem_en, out_valid, out_last, mem_addr, out_data, out_plane}), 256'(0));
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    words = 0;
    done_cnt = 0;
    push_image();
    first_word_timing();
    run_image(1'b0);
    repeat (5) @(negedge clk);
    check("run2_words", 256'(words), 256'(48));
    check("run2_done_cnt", 256'(done_cnt), 256'(1));

    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed so far", pass, chk);
    $fatal(1);
  end
endmodule
